// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 encodings,
// memory access-type constants and the controller state enum.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Loads are sequenced one byte per cycle using this access type
   localparam logic [2:0] MEM_ACC_BYTE = 3'b100;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STORE,
      RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_align_ext.sv
// Combinational helper: legality/alignment check and byte count for an
// incoming request, plus sign/zero extension of assembled load data.
module lsu_align_ext
   import lsu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 14
) (
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   output logic        fault_o,
   output logic [2:0]  nbytes_o,
   input  logic [2:0]  ext_funct3_i,
   input  logic [31:0] ext_raw_i,
   output logic [31:0] ext_data_o
);

   // Decide the access size and whether the request must be rejected
   always_comb begin
      fault_o  = 1'b0;
      nbytes_o = 3'd1;
      case (req_funct3_i)
         F3_B:  nbytes_o = 3'd1;
         F3_BU: begin
            nbytes_o = 3'd1;
            fault_o  = req_we_i;
         end
         F3_H: begin
            nbytes_o = 3'd2;
            fault_o  = req_addr_i[0];
         end
         F3_HU: begin
            nbytes_o = 3'd2;
            fault_o  = req_addr_i[0] | req_we_i;
         end
         F3_W: begin
            nbytes_o = 3'd4;
            fault_o  = (req_addr_i[1:0] != 2'b00);
         end
         default: fault_o = 1'b1;
      endcase
      if ((req_addr_i >> ADDRESS_WIDTH) != 32'd0) begin
         fault_o = 1'b1;
      end
   end

   // Widen the little-endian assembled bytes according to the load type
   always_comb begin
      ext_data_o = ext_raw_i;
      case (ext_funct3_i)
         F3_B:    ext_data_o = {{24{ext_raw_i[7]}}, ext_raw_i[7:0]};
         F3_H:    ext_data_o = {{16{ext_raw_i[15]}}, ext_raw_i[15:0]};
         F3_BU:   ext_data_o = {24'd0, ext_raw_i[7:0]};
         F3_HU:   ext_data_o = {16'd0, ext_raw_i[15:0]};
         default: ext_data_o = ext_raw_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs stores in a
// single memory cycle and loads as a sequence of byte reads, then holds a
// response until the pipeline consumes it.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 14
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [2:0]               req_funct3,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [31:0]              resp_rdata,
   output logic                     resp_fault,
   output logic                     mem_wEn,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [2:0]               mem_access_type,
   output logic [31:0]              mem_dataIn,
   input  logic [31:0]              mem_dataOut
);

   lsu_state_e               state_q, state_d;
   logic                     we_q, we_d;
   logic [2:0]               funct3_q, funct3_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic [31:0]              raw_q, raw_d;
   logic [2:0]               cnt_q, cnt_d;
   logic [2:0]               nbytes_q, nbytes_d;
   logic                     fault_q, fault_d;

   logic                     chkFault;
   logic [2:0]               chkNbytes;
   logic [31:0]              extData;
   logic [1:0]               byteIdx;
   logic                     unused_dataHi;

   assign byteIdx       = 2'(cnt_q - 3'd1);
   assign unused_dataHi = ^mem_dataOut[31:8];

   lsu_align_ext #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_align_ext (
      .req_we_i    (req_we),
      .req_funct3_i(req_funct3),
      .req_addr_i  (req_addr),
      .fault_o     (chkFault),
      .nbytes_o    (chkNbytes),
      .ext_funct3_i(funct3_q),
      .ext_raw_i   (raw_q),
      .ext_data_o  (extData)
   );

   // State and request registers; reset discards any partial access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         raw_q    <= 32'd0;
         cnt_q    <= 3'd0;
         nbytes_q <= 3'd0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         raw_q    <= raw_d;
         cnt_q    <= cnt_d;
         nbytes_q <= nbytes_d;
         fault_q  <= fault_d;
      end
   end

   // Next-state and output decode; memory outputs are zero unless active
   always_comb begin
      state_d         = state_q;
      we_d            = we_q;
      funct3_d        = funct3_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      raw_d           = raw_q;
      cnt_d           = cnt_q;
      nbytes_d        = nbytes_q;
      fault_d         = fault_q;
      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      resp_rdata      = 32'd0;
      resp_fault      = 1'b0;
      mem_wEn         = 1'b0;
      mem_addr        = '0;
      mem_access_type = 3'd0;
      mem_dataIn      = 32'd0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr[ADDRESS_WIDTH-1:0];
               wdata_d  = req_wdata;
               raw_d    = 32'd0;
               cnt_d    = 3'd0;
               nbytes_d = chkNbytes;
               fault_d  = chkFault;
               if (chkFault) begin
                  state_d = RESP;
               end else if (req_we) begin
                  state_d = STORE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         STORE: begin
            mem_wEn         = 1'b1;
            mem_addr        = addr_q;
            mem_access_type = funct3_q;
            mem_dataIn      = wdata_q;
            state_d         = RESP;
         end
         LOAD: begin
            if (cnt_q < nbytes_q) begin
               mem_addr        = addr_q + ADDRESS_WIDTH'(cnt_q);
               mem_access_type = MEM_ACC_BYTE;
            end
            if (cnt_q != 3'd0) begin
               raw_d[{byteIdx, 3'b000} +: 8] = mem_dataOut[7:0];
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == nbytes_q) begin
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_fault = fault_q;
            resp_rdata = (fault_q || we_q) ? 32'd0 : extData;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 14, the byte-address width of the data memory port.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  the pipeline is presenting a memory request.
REQ-005 SHALL have port req_ready  output  1  the unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  the byte address.
REQ-009 SHALL have port req_wdata  input  32  the store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  a response is available.
REQ-011 SHALL have port resp_ready  input  1  the pipeline consumes the response.
REQ-012 SHALL have port resp_rdata  output  32  the extended load data; 0 for stores and faults.
REQ-013 SHALL have port resp_fault  output  1  the access was misaligned, out of range or illegal.
REQ-014 SHALL have port mem_wEn  output  1  the memory write enable.
REQ-015 SHALL have port mem_addr  output  ADDRESS_WIDTH  the memory byte address.
REQ-016 SHALL have port mem_access_type  output  3  the memory access type.
REQ-017 SHALL have port mem_dataIn  output  32  the memory write data.
REQ-018 SHALL have port mem_dataOut  input  32  the memory read data, registered one cycle after the address.

Function
REQ-019 SHALL use FSM states IDLE, LOAD, STORE, RESP; req_ready=1 only in IDLE, and a request is accepted on req_valid&&req_ready (cycle T).
REQ-020 SHALL fault, with resp_valid in T+1 and no memory activity, when any of these hold: H/HU with addr[0]=1; W with addr[1:0]!=0; addr[31:ADDRESS_WIDTH]!=0; funct3 011/110/111; or a store with funct3 100/101.
REQ-021 Store: SHALL drive mem_wEn=1, mem_addr=addr, mem_access_type=funct3 and mem_dataIn=wdata for exactly cycle T+1, and then assert resp_valid from T+2.
REQ-022 Load of N bytes (B/BU N=1, H/HU N=2, W N=4): SHALL drive mem_addr=addr+k with mem_access_type=3'b100 and mem_wEn=0 in cycle T+1+k, for k=0..N-1.
REQ-023 SHALL capture byte k from mem_dataOut[7:0] at the end of cycle T+2+k and place it at resp bits [8k+7:8k] (little-endian).
REQ-024 SHALL assert resp_valid from cycle T+N+2, so LB has a 3-cycle and LW a 6-cycle request-to-response latency.
REQ-025 SHALL sign-extend B/H results from bit 7/15, and zero-extend BU/HU results.
REQ-026 SHALL hold resp_valid, resp_rdata and resp_fault stable until resp_ready; SHALL return to IDLE in the cycle after resp_valid&&resp_ready, with no same-cycle accept.
REQ-027 SHALL hold mem_wEn=0 outside the STORE cycle, and mem_addr/mem_access_type/mem_dataIn=0 whenever idle.
REQ-028 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-029 On rst_n=0 the unit SHALL immediately go to IDLE and drive all outputs 0 except req_ready=1, including mid-load or mid-store, discarding partial data.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-031 SHALL take the funct3 encodings, the memory access-type constants and the state enum from a shared package, lsu_pkg.
REQ-032 SHALL place extension and alignment checks in one combinational sub-module, lsu_align_ext.

Verification
REQ-033 SHALL cover: SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> mem_wEn high exactly one cycle; resp_rdata=0xDEADBEEF at T+6; fault=0.
REQ-034 SHALL cover: SB 0x80 at 0x21, then LB 0x21 -> rdata=0xFFFFFF80; LBU 0x21 -> 0x00000080; LB resp at T+3.
REQ-035 SHALL cover: LH 0x23 and LW 0x22 -> resp_fault=1 at T+1, rdata=0, no mem_addr change.
REQ-036 SHALL cover: LW 0x4000 and funct3 011 -> resp_fault=1; store funct3 100 -> fault.
REQ-037 SHALL cover: resp_ready held low 5 cycles -> resp outputs stable and req_ready=0 throughout; accept resumes the cycle after the handshake.
REQ-038 SHALL cover: rst_n pulsed low during the third byte of an LW -> outputs 0 and req_ready=1 immediately; a following LHU 0x10 returns 0x0000BEEF.
